// File: rtl/cdb_pkg.sv
// Common-data-bus arbiter package: default sizing, index type and the
// pointer wrap helper shared by the arbiter files.
package cdb_pkg;

    localparam int unsigned CDB_N_REQ = 4;
    localparam int unsigned CDB_IDX_W = $clog2(CDB_N_REQ);

    typedef logic [CDB_IDX_W-1:0] req_idx_t;

    // (idx + 1) mod n with an explicit wrap, so non-power-of-2 n never
    // relies on natural overflow.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/cdb_arbiter_rr_priority_select.sv
// Round-robin priority selector: rotates the request vector so ptr lands at
// bit 0, picks the lowest set bit, then maps the winner back to its real index.
// Purely combinational.
module rr_priority_select
    import cdb_pkg::*;
#(
    parameter int unsigned N_REQ = CDB_N_REQ,
    parameter int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] request,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] index,
    output logic             found
);

    logic [N_REQ-1:0] rot;
    logic [IDX_W-1:0] lo_idx;
    logic [IDX_W:0]   sum;

    // Rotate right by ptr: rot[i] is the requester i places after ptr.
    always_comb begin
        rot = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            rot[i] = request[IDX_W'((i + 32'(ptr)) % N_REQ)];
        end
    end

    // Fixed-priority encode of the rotated vector (bit 0 highest).
    always_comb begin
        found  = 1'b0;
        lo_idx = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!found && rot[i]) begin
                found  = 1'b1;
                lo_idx = IDX_W'(i);
            end
        end
    end

    // Rotate back: winner = (lo_idx + ptr) mod N_REQ with explicit wrap.
    always_comb begin
        sum = {1'b0, lo_idx} + {1'b0, ptr};
        if (sum >= (IDX_W+1)'(N_REQ)) begin
            sum = sum - (IDX_W+1)'(N_REQ);
        end
        index = sum[IDX_W-1:0];
        grant = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            grant[i] = found && (index == IDX_W'(i));
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: grants one FU output buffer per cycle, round-robin
// from a registered priority pointer. Grant is combinational so the winner
// drives the bus this cycle and pops on the next edge.
// Optional performance counters are built when CDB_ARB_PERF_EN is defined.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int unsigned N_REQ = CDB_N_REQ,
    parameter int unsigned IDX_W = $clog2(N_REQ)
`ifdef CDB_ARB_PERF_EN
    ,
    parameter int unsigned CNT_WIDTH = 32
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] request,
    input  logic             bus_stall,
    output logic [N_REQ-1:0] grant,
    output logic             bus_valid,
    output logic [IDX_W-1:0] grant_idx
`ifdef CDB_ARB_PERF_EN
    ,
    output logic [CNT_WIDTH-1:0] grant_count [N_REQ],
    output logic [CNT_WIDTH-1:0] stall_cycles,
    output logic [CNT_WIDTH-1:0] conflict_cycles
`endif
);

    logic [IDX_W-1:0] ptr;
    logic [N_REQ-1:0] sel_grant;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_found;

    rr_priority_select #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_select (
        .request (request),
        .ptr     (ptr),
        .grant   (sel_grant),
        .index   (sel_idx),
        .found   (sel_found)
    );

    // Reset and stall gating of the selector result.
    always_comb begin
        grant     = '0;
        bus_valid = 1'b0;
        grant_idx = '0;
        if (!reset && !bus_stall && sel_found) begin
            grant     = sel_grant;
            bus_valid = 1'b1;
            grant_idx = sel_idx;
        end
    end

    // Priority pointer moves just past the winner; holds when nothing granted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (bus_valid) begin
            ptr <= IDX_W'(wrap_inc(32'(grant_idx), N_REQ));
        end
    end

`ifdef CDB_ARB_PERF_EN
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    // Per-requester saturating grant counters.
    for (genvar g = 0; g < N_REQ; g++) begin : g_grant_cnt
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                grant_count[g] <= '0;
            end else if (grant[g] && (grant_count[g] != '1)) begin
                grant_count[g] <= grant_count[g] + CNT_ONE;
            end
        end
    end

    // Saturating count of edges where a pending request was stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (bus_stall && (|request) && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + CNT_ONE;
        end
    end

    // Saturating count of granted edges that had competing requests.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            conflict_cycles <= '0;
        end else if (bus_valid && ($countones(request) > 1) && (conflict_cycles != '1)) begin
            conflict_cycles <= conflict_cycles + CNT_ONE;
        end
    end
`endif

endmodule
